// File: rtl/is_pkg_uart_controller.sv
// Shared types and helpers for the UART controller: frame defaults, ASCII
// control characters, the hex-response serializer state and nibble encoding.
package is_pkg_uart_controller;

    localparam int DATA_TX_W = 92;
    localparam int K         = DATA_TX_W / 4;

    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;

    typedef enum logic [2:0] {
        IDLE,
        SEND_HEX,
        SEND_CR,
        SEND_LF,
        DONE
    } state_t;

    function automatic logic [7:0] nib2ascii(input logic [3:0] nibble, input logic uppercase);
        if (nibble < 4'd10) begin
            return 8'h30 + {4'h0, nibble};
        end
        return (uppercase ? 8'h41 : 8'h61) + {4'h0, nibble} - 8'd10;
    endfunction

endpackage

// File: rtl/uart_resp_hex_tx_if.sv
// Response-word and ASCII byte-stream handshakes of the hex response serializer.
interface uart_resp_hex_tx_if #(
    parameter int DATA_TX_W = is_pkg_uart_controller::DATA_TX_W
);
    logic [DATA_TX_W-1:0] resp_data;
    logic                 resp_valid;
    logic                 resp_ready;
    logic [7:0]           tx_data;
    logic                 tx_valid;
    logic                 tx_ready;

    modport master (
        output resp_data, resp_valid, tx_ready,
        input  resp_ready, tx_data, tx_valid
    );

    modport slave (
        input  resp_data, resp_valid, tx_ready,
        output resp_ready, tx_data, tx_valid
    );
endinterface

// File: rtl/uart_resp_hex_tx_hex_ascii_enc.sv
// Combinational nibble-to-ASCII hex encoder, reusable by any debug-print path.
module hex_ascii_enc
    import is_pkg_uart_controller::*;
#(
    parameter bit UPPERCASE = 1'b1
) (
    input  logic [3:0] nibble,
    output logic [7:0] ascii
);

    assign ascii = nib2ascii(nibble, UPPERCASE);

endmodule

// File: rtl/uart_resp_hex_tx.sv
// Serializes one response word into ASCII hex characters (MS nibble first),
// optionally terminated by CR LF, over a valid/ready byte stream to uart_tx.
module uart_resp_hex_tx #(
    parameter int DATA_TX_W = is_pkg_uart_controller::DATA_TX_W,
    parameter bit ADD_CRLF  = 1'b1,
    parameter bit UPPERCASE = 1'b1
) (
    input  logic               clk,
    input  logic               rst_n,
    uart_resp_hex_tx_if.slave  bus,
    output logic               busy,
    output logic               frame_done
);
    import is_pkg_uart_controller::*;

    localparam int                K        = DATA_TX_W / 4;
    localparam int                CNT_W    = (K > 1) ? $clog2(K) : 1;
    localparam logic [CNT_W-1:0]  LAST_CHR = CNT_W'(K - 1);

    if (DATA_TX_W % 4 != 0) begin : g_width_chk
        $error("uart_resp_hex_tx: DATA_TX_W must be a multiple of 4");
    end

    state_t               state_q, state_d;
    logic [DATA_TX_W-1:0] shift_q, shift_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;

    logic       resp_ready_q, resp_ready_d;
    logic       tx_valid_q, tx_valid_d;
    logic [7:0] tx_data_q, tx_data_d;
    logic       busy_q, busy_d;
    logic       frame_done_q, frame_done_d;

    logic       resp_hs, tx_hs, last_chr;
    logic [7:0] hex_chr;

    assign resp_hs  = bus.resp_valid & resp_ready_q;
    assign tx_hs    = tx_valid_q & bus.tx_ready;
    assign last_chr = (cnt_q == LAST_CHR);

    // The encoder looks at the word as it will be after this edge, so the next
    // character is registered in the same edge that consumes the current one.
    hex_ascii_enc #(.UPPERCASE(UPPERCASE)) u_enc (
        .nibble (shift_d[DATA_TX_W-1 -: 4]),
        .ascii  (hex_chr)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            shift_q      <= '0;
            cnt_q        <= '0;
            resp_ready_q <= 1'b0;
            tx_valid_q   <= 1'b0;
            tx_data_q    <= 8'h00;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            // NOTE: non-blocking here so every register samples pre-edge values
            // regardless of statement order.
            state_q      <= state_d;
            shift_q      <= shift_d;
            cnt_q        <= cnt_d;
            resp_ready_q <= resp_ready_d;
            tx_valid_q   <= tx_valid_d;
            tx_data_q    <= tx_data_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
        end
    end

    always_comb begin
        // NOTE: default first so no path through the case leaves state_d unassigned
        // (which would infer a latch).
        state_d = state_q;
        unique case (state_q)
            IDLE:     if (resp_hs) state_d = SEND_HEX;
            SEND_HEX: if (tx_hs && last_chr) state_d = ADD_CRLF ? SEND_CR : DONE;
            SEND_CR:  if (tx_hs) state_d = SEND_LF;
            SEND_LF:  if (tx_hs) state_d = DONE;
            DONE:     state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_comb begin
        shift_d      = shift_q;
        cnt_d        = cnt_q;
        resp_ready_d = 1'b0;
        tx_valid_d   = 1'b0;
        tx_data_d    = 8'h00;
        busy_d       = 1'b1;
        frame_done_d = 1'b0;

        if (resp_hs) begin
            shift_d = bus.resp_data;
            cnt_d   = '0;
        end else if (state_q == SEND_HEX && tx_hs && !last_chr) begin
            shift_d = shift_q << 4;
            cnt_d   = cnt_q + 1'b1;
        end

        unique case (state_d)
            IDLE: begin
                resp_ready_d = 1'b1;
                busy_d       = 1'b0;
            end
            SEND_HEX: begin
                // The cycle right after acceptance only loads the word.
                tx_valid_d = (state_q != IDLE);
                tx_data_d  = (state_q != IDLE) ? hex_chr : 8'h00;
            end
            SEND_CR: begin
                tx_valid_d = 1'b1;
                tx_data_d  = ASCII_CR;
            end
            SEND_LF: begin
                tx_valid_d = 1'b1;
                tx_data_d  = ASCII_LF;
            end
            DONE:    frame_done_d = 1'b1;
            default: busy_d       = 1'b0;
        endcase
    end

    assign bus.resp_ready = resp_ready_q;
    assign bus.tx_valid   = tx_valid_q;
    assign bus.tx_data    = tx_data_q;
    assign busy           = busy_q;
    assign frame_done     = frame_done_q;

endmodule

// File: tb/tb_uart_resp_hex_tx.sv
// Directed + randomized bench for uart_resp_hex_tx; bytes are checked against a
// string-lookup model of the hex/CRLF frame format.
module tb_uart_resp_hex_tx;

    localparam int W = 92;
    localparam int K = W / 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    uart_resp_hex_tx_if #(.DATA_TX_W(W)) if_a ();
    uart_resp_hex_tx_if #(.DATA_TX_W(W)) if_b ();
    logic busy_a, done_a, busy_b, done_b;

    uart_resp_hex_tx #(.DATA_TX_W(W), .ADD_CRLF(1'b1), .UPPERCASE(1'b1)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(if_a), .busy(busy_a), .frame_done(done_a)
    );

    uart_resp_hex_tx #(.DATA_TX_W(W), .ADD_CRLF(1'b0), .UPPERCASE(1'b0)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(if_b), .busy(busy_b), .frame_done(done_b)
    );

    int checks = 0;
    int errors = 0;

    logic [7:0]   got_q[$];
    logic [7:0]   exp_q[$];
    logic         rv, tr;
    logic [W-1:0] rd;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference frame: K characters looked up from the word, then optional CR LF.
    function automatic void build_exp(input logic [W-1:0] w, input bit crlf, input bit upper);
        string hx;
        hx = upper ? "0123456789ABCDEF" : "0123456789abcdef";
        exp_q.delete();
        for (int i = 0; i < K; i++) begin
            int nib;
            nib = int'(w[W-1-4*i -: 4]);
            exp_q.push_back(hx[nib]);
        end
        if (crlf) begin
            exp_q.push_back(8'h0D);
            exp_q.push_back(8'h0A);
        end
    endfunction

    task automatic apply(input bit sel);
        if (sel) begin
            if_b.resp_valid = rv; if_b.resp_data = rd; if_b.tx_ready = tr;
            if_a.resp_valid = 1'b0;
        end else begin
            if_a.resp_valid = rv; if_a.resp_data = rd; if_a.tx_ready = tr;
            if_b.resp_valid = 1'b0;
        end
    endtask

    task automatic get_out(input bit sel, output logic rr, output logic tv,
                           output logic [7:0] td, output logic bz, output logic fd);
        if (sel) begin
            rr = if_b.resp_ready; tv = if_b.tx_valid; td = if_b.tx_data; bz = busy_b; fd = done_b;
        end else begin
            rr = if_a.resp_ready; tv = if_a.tx_valid; td = if_a.tx_data; bz = busy_a; fd = done_a;
        end
    endtask

    task automatic pick_ready(input bit stall, inout int stall_left);
        if (!stall) tr = 1'b1;
        else if (stall_left > 0) begin tr = 1'b0; stall_left--; end
        else if ($urandom_range(0, 19) == 0) begin tr = 1'b0; stall_left = 9; end
        else tr = ($urandom_range(0, 2) != 0);
    endtask

    // One frame on DUT `sel`. inj_at >= 0 raises resp_valid with inj_word once that
    // many bytes have gone; abort_at >= 0 asserts reset between edges at that point.
    task automatic run_frame(input bit sel, input logic [W-1:0] word, input bit stall,
                             input int inj_at, input logic [W-1:0] inj_word,
                             input int abort_at, input string tag);
        logic rr, tv, bz, fd;
        logic [7:0] td, prev_td;
        bit prev_hold, prev_tv;
        int cyc, nvalid, ndone, rises, stall_left, exp_lat;

        prev_hold = 0; prev_tv = 0; prev_td = 8'h00;
        nvalid = 0; ndone = 0; rises = 0; stall_left = 0; cyc = 0;

        get_out(sel, rr, tv, td, bz, fd);
        while (!rr && cyc < 100) begin
            @(negedge clk);
            cyc++;
            get_out(sel, rr, tv, td, bz, fd);
        end
        check({tag, " idle_ready"}, 128'(rr), 128'(1));

        got_q.delete();
        cyc = 0;
        rv = 1'b1; rd = word;
        pick_ready(stall, stall_left);
        apply(sel);

        while (cyc < 4000) begin
            @(negedge clk);
            cyc++;
            get_out(sel, rr, tv, td, bz, fd);
            if (prev_hold) begin
                check({tag, " stall_valid"}, 128'(tv), 128'(1));
                check({tag, " stall_data"}, 128'(td), 128'(prev_td));
            end
            if (fd) ndone++;
            if (tv) nvalid++;
            if (tv && !prev_tv) rises++;
            if (abort_at >= 0 && got_q.size() == abort_at) begin
                #2 rst_n = 1'b0;
                #1 get_out(sel, rr, tv, td, bz, fd);
                check({tag, " rst_tx_valid"}, 128'(tv), 128'(0));
                check({tag, " rst_busy"}, 128'(bz), 128'(0));
                check({tag, " rst_frame_done"}, 128'(fd), 128'(0));
                check({tag, " rst_resp_ready"}, 128'(rr), 128'(0));
                return;
            end
            if (rr) break;
            check({tag, " busy"}, 128'(bz), 128'(1));
            if (inj_at >= 0 && got_q.size() >= inj_at) begin
                rv = 1'b1; rd = inj_word;
            end else begin
                rv = 1'b0;
            end
            pick_ready(stall, stall_left);
            apply(sel);
            prev_hold = tv && !tr;
            prev_tv   = tv;
            prev_td   = td;
            if (tv && tr) got_q.push_back(td);
        end
        check({tag, " no_timeout"}, 128'(cyc < 4000), 128'(1));

        build_exp(word, !sel, !sel);
        check({tag, " byte_count"}, 128'(got_q.size()), 128'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check($sformatf("%s byte%0d", tag, i), 128'(got_q[i]), 128'(exp_q[i]));
        check({tag, " frame_done_pulses"}, 128'(ndone), 128'(1));
        check({tag, " valid_runs"}, 128'(rises), 128'(1));
        if (!stall) begin
            exp_lat = 1 + K + (sel ? 0 : 2) + 1;
            check({tag, " ready_latency"}, 128'(cyc - 1), 128'(exp_lat));
            check({tag, " valid_cycles"}, 128'(nvalid), 128'(exp_q.size()));
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [95:0] r;
        logic [W-1:0] w1, w2;

        rv = 1'b0; tr = 1'b0; rd = '0;
        if_a.resp_valid = 1'b0; if_a.resp_data = '0; if_a.tx_ready = 1'b0;
        if_b.resp_valid = 1'b0; if_b.resp_data = '0; if_b.tx_ready = 1'b0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        check("reset resp_ready", 128'(if_a.resp_ready), 128'(0));
        check("reset tx_valid", 128'(if_a.tx_valid), 128'(0));
        check("reset tx_data", 128'(if_a.tx_data), 128'(0));
        check("reset busy", 128'(busy_a), 128'(0));
        check("reset frame_done", 128'(done_a), 128'(0));
        repeat (2) @(negedge clk);
        check("held reset resp_ready", 128'(if_a.resp_ready), 128'(0));
        rst_n = 1'b1;
        @(negedge clk);
        check("release resp_ready", 128'(if_a.resp_ready), 128'(1));

        run_frame(0, 92'h0123456789ABCDEF0123456, 0, -1, '0, -1, "basic");
        run_frame(0, 92'h0123456789ABCDEF0123456, 1, -1, '0, -1, "backpressure");

        run_frame(0, 92'h0123456789ABCDEF0123456, 0, 5, {W{1'b1}}, -1, "reject_busy");
        run_frame(0, {W{1'b1}}, 0, -1, '0, -1, "all_f");

        run_frame(1, 92'hABCDEF0123456789ABCDEF0, 0, -1, '0, -1, "lowercase");
        if (got_q.size() >= 3) begin
            check("lowercase first", 128'(got_q[0]), 128'(8'h61));
            check("lowercase second", 128'(got_q[1]), 128'(8'h62));
            check("lowercase third", 128'(got_q[2]), 128'(8'h63));
        end
        run_frame(1, '0, 0, -1, '0, -1, "all_zero");

        for (int i = 0; i < 6; i++) begin
            r = {$urandom, $urandom, $urandom};
            run_frame(i[0], r[W-1:0], 1, -1, '0, -1, $sformatf("random%0d", i));
        end

        r = {$urandom, $urandom, $urandom};
        run_frame(0, r[W-1:0], 0, -1, '0, 7, "abort");
        repeat (2) @(negedge clk);
        check("abort held resp_ready", 128'(if_a.resp_ready), 128'(0));
        rst_n = 1'b1;
        @(posedge clk);
        #1 check("abort release resp_ready", 128'(if_a.resp_ready), 128'(1));
        @(negedge clk);
        r = {$urandom, $urandom, $urandom};
        run_frame(0, r[W-1:0], 0, -1, '0, -1, "after_reset");

        r = {$urandom, $urandom, $urandom};
        w1 = r[W-1:0];
        r = {$urandom, $urandom, $urandom};
        w2 = r[W-1:0];
        run_frame(0, w1, 0, 0, w2, -1, "b2b_first");
        run_frame(0, w2, 0, -1, '0, -1, "b2b_second");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_resp_hex_tx.md
Name: uart_resp_hex_tx

Overview:
Response-side serializer for the UART controller, in the transmit direction. It accepts one DATA_TX_W-bit response word per transaction and emits it as K ASCII hex characters, most-significant nibble first, optionally followed by CR LF. Characters go one byte at a time over a valid/ready byte stream into the UART transmitter. It sits between the command/response logic and uart_tx.

Parameters:
DATA_TX_W, 92, response word width; must be a multiple of 4 (elaboration-time assertion).
K, DATA_TX_W/4, hex characters per frame; derived, not overridable.
ADD_CRLF, 1, 1 = append 0x0D 0x0A after the hex characters; 0 = hex characters only.
UPPERCASE, 1, 1 = A-F map to 0x41-0x46; 0 = a-f map to 0x61-0x66.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
resp_data  in  DATA_TX_W  response word; sampled on the resp handshake
resp_valid  in  1  response word available
resp_ready  out  1  block idle and able to accept a word
tx_data  out  8  ASCII byte to uart_tx
tx_valid  out  1  tx_data is valid
tx_ready  in  1  uart_tx accepts the byte this cycle
busy  out  1  frame in progress
frame_done  out  1  one-cycle pulse after the last byte handshake

Behaviour:
- Interface decision: one clock (clk); reset rst_n is asynchronous and active-low.
- Reset values: resp_ready=0 while reset is asserted, then 1 on the first clk edge after release. tx_valid=0, tx_data=8'h00, busy=0, frame_done=0. Internal shift register and counter are cleared.
- All outputs are registered.
- Handshakes:
  - Resp handshake = resp_valid & resp_ready.
  - Tx handshake = tx_valid & tx_ready.
  - resp_ready is high only in IDLE. resp_valid while busy is ignored and must not corrupt the frame in flight.
- States:
  - IDLE: resp_ready=1. On a resp handshake, latch resp_data into the shift register, set chr_cnt=0 and go to SEND_HEX. On the next edge, tx_valid=1 and tx_data = ASCII(MS nibble); first byte appears 1 cycle after the handshake.
  - SEND_HEX: tx_data/tx_valid are held stable until a tx handshake.
    - On a handshake with chr_cnt<K-1: shift left 4, increment chr_cnt, and load the next character in the same edge. tx_valid stays high, so there is no bubble.
    - On a handshake with chr_cnt=K-1: go to SEND_CR if ADD_CRLF, else to DONE.
  - SEND_CR: tx_data=8'h0D. Handshake moves to SEND_LF.
  - SEND_LF: tx_data=8'h0A. Handshake moves to DONE.
  - DONE: one cycle, tx_valid=0, frame_done=1, then IDLE.
- Throughput: with tx_ready tied high, a frame takes 1 + K + 2*ADD_CRLF + 1 cycles from the resp handshake to resp_ready high again. That is 27 cycles at defaults (25 byte cycles).
- tx_ready low stalls indefinitely with no data change. tx_ready high while tx_valid=0 has no effect.
- busy = 1 in SEND_HEX, SEND_CR, SEND_LF and DONE.
- Nibble mapping:
  - 0-9 map to 0x30-0x39.
  - 10-15 map to 0x41-0x46, or 0x61-0x66 when UPPERCASE=0.
  - An all-zero word is sent as K '0' characters (no suppression).
- Reset mid-frame: the frame is abandoned immediately (asynchronously). There is no resumption, and frame_done is not pulsed.

Decomposition:
- Add to package is_pkg_uart_controller:
  - ASCII_CR=8'h0D, ASCII_LF=8'h0A
  - a typedef enum for the state (IDLE, SEND_HEX, SEND_CR, SEND_LF, DONE)
  - a function nib2ascii(nibble, uppercase)
- DATA_TX_W and K come from the package defaults.
- One small sub-module is natural: hex_ascii_enc (4-bit in, 8-bit out, combinational). It is reusable by other debug-print paths. Everything else stays in one module.

Test Plan:
- Basic frame: resp_data=92'h0123456789ABCDEF0123456, tx_ready=1.
  - Byte stream is "0123456789ABCDEF0123456" then 0D 0A, i.e. 0x30..0x39, 0x41..0x46, 0x30..0x36, 0x0D, 0x0A.
  - tx_valid is continuous for 25 cycles; frame_done pulses once; resp_ready returns 27 cycles after the handshake.
- Backpressure: same word with tx_ready toggling pseudo-randomly, including 10-cycle low stalls.
  - Identical byte sequence; tx_data stable whenever tx_valid=1 and tx_ready=0; no byte dropped or duplicated.
- Busy rejection: assert resp_valid with a new word 92'hFFF...F at chr_cnt=5 of a frame.
  - resp_ready stays 0 and the current frame completes unchanged.
  - The new word is accepted in IDLE and sends 23 'F' (0x46) characters.
- Parameter variants:
  - ADD_CRLF=0, UPPERCASE=0, word 92'hABC...: first bytes are 0x61 0x62 0x63 and the frame has exactly 23 bytes, with no 0D/0A.
  - All-zero word: 23 bytes of 0x30.
- Reset mid-frame: assert rst_n=0 asynchronously (between edges) after the 7th byte.
  - tx_valid, busy and frame_done drop to 0 immediately; resp_ready is 0 during reset and 1 on the first edge after release.
  - The next word is transmitted from its first nibble.
- Back-to-back frames: resp_valid held high with two words.
  - Second frame's first byte appears 1 cycle after the handshake that follows DONE.
  - No bytes of the two frames interleave.
